// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RISC-V pipeline: program counter, instruction fetch, IF/ID register.
// Define FETCH_PERF_EN to add saturating stall/flush cycle counters (stall_cycles, flush_cycles).
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [7:0]  if_id_pc,
  output logic        if_id_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles,
`endif
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } mode_e;

  mode_e       mode;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  id_pc_q, id_pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Mode is purely a function of this cycle's inputs; redirect overrides stall.
  always_comb begin
    mode = RUN;
    if (redirect_valid) begin
      mode = FLUSH;
    end else if (stall) begin
      mode = HOLD;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (mode)
      FLUSH: begin
        pc_d    = {redirect_pc[7:2], 2'b00};
        instr_d = NOP_INSTR;
        id_pc_d = pc_q;
        valid_d = 1'b0;
        err_d   = err_q | (redirect_pc[1:0] != 2'b00);
      end
      RUN: begin
        pc_d    = pc_q + 8'd4;
        instr_d = imem_instr;
        id_pc_d = pc_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      id_pc_q <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc     = id_pc_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = err_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mode == HOLD && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (mode == FLUSH && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table through a scoreboard queue,
// plus hand sequences for PC wrap, asynchronous mid-stream reset and the optional counters.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_EN
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles),
`endif
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM
  logic [31:0] rom [0:63];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h00c08093;
    rom[1] = 32'h00010463;
    rom[2] = 32'h00f10113;
    rom[3] = 32'h00103023;
  end
  assign imem_instr = rom[imem_addr[7:2]];

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        valid;
    logic [7:0]  addr;
    logic        err;
  } exp_t;

  typedef struct {
    logic        st;
    logic        rv;
    logic [7:0]  rpc;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    cmp({tag, ".instr"}, if_id_instr, e.instr);
    cmp({tag, ".pc"}, {24'h0, if_id_pc}, {24'h0, e.pc});
    cmp({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    cmp({tag, ".addr"}, {24'h0, imem_addr}, {24'h0, e.addr});
    cmp({tag, ".err"}, {31'h0, misalign_err}, {31'h0, e.err});
  endtask

  // Drive one cycle of inputs, queue the expectation, clock, then compare after the edge.
  task automatic step(input string tag, input logic st, input logic rv, input logic [7:0] rpc,
                      input exp_t e);
    exp_t got;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_outputs(tag, got);
    end
    $display("txn %s st=%0b rv=%0b rpc=%02h -> instr=%08h pc=%02h v=%0b addr=%02h err=%0b",
             tag, st, rv, rpc, if_id_instr, if_id_pc, if_id_valid, imem_addr, misalign_err);
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [7:0] pc,
                              input logic valid, input logic [7:0] addr, input logic err);
    exp_t r;
    r.instr = instr; r.pc = pc; r.valid = valid; r.addr = addr; r.err = err;
    return r;
  endfunction

  localparam logic [31:0] NOP = 32'h00000013;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'h00, mk(32'h00c08093, 8'h00, 1'b1, 8'h04, 1'b0)};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, mk(32'h00010463, 8'h04, 1'b1, 8'h08, 1'b0)};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, mk(32'h00010463, 8'h04, 1'b1, 8'h08, 1'b0)};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, mk(32'h00010463, 8'h04, 1'b1, 8'h08, 1'b0)};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, mk(32'h00010463, 8'h04, 1'b1, 8'h08, 1'b0)};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, mk(32'h00f10113, 8'h08, 1'b1, 8'h0C, 1'b0)};
    vecs[6]  = '{1'b0, 1'b1, 8'h08, mk(NOP,          8'h0C, 1'b0, 8'h08, 1'b0)};
    vecs[7]  = '{1'b0, 1'b1, 8'h0C, mk(NOP,          8'h08, 1'b0, 8'h0C, 1'b0)};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, mk(32'h00103023, 8'h0C, 1'b1, 8'h10, 1'b0)};
    vecs[9]  = '{1'b1, 1'b1, 8'h1C, mk(NOP,          8'h10, 1'b0, 8'h1C, 1'b0)};
    vecs[10] = '{1'b0, 1'b1, 8'h1C, mk(NOP,          8'h1C, 1'b0, 8'h1C, 1'b0)};
    vecs[11] = '{1'b0, 1'b0, 8'h00, mk(32'hA0000007, 8'h1C, 1'b1, 8'h20, 1'b0)};
    vecs[12] = '{1'b0, 1'b1, 8'h1E, mk(NOP,          8'h20, 1'b0, 8'h1C, 1'b1)};
    vecs[13] = '{1'b1, 1'b0, 8'h00, mk(NOP,          8'h20, 1'b0, 8'h1C, 1'b1)};
    vecs[14] = '{1'b0, 1'b0, 8'h00, mk(32'hA0000007, 8'h1C, 1'b1, 8'h20, 1'b1)};

    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #1;
    check_outputs("reset", mk(NOP, 8'h00, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].e);
    end

    // PC wrap from FC to 00
    step("to_fc", 1'b0, 1'b1, 8'hFC, mk(NOP, 8'h20, 1'b0, 8'hFC, 1'b1));
    step("wrap", 1'b0, 1'b0, 8'h00, mk(32'hA000003F, 8'hFC, 1'b1, 8'h00, 1'b1));
    step("after_wrap", 1'b0, 1'b0, 8'h00, mk(32'h00c08093, 8'h00, 1'b1, 8'h04, 1'b1));

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", mk(NOP, 8'h00, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 1'b0, 1'b0, 8'h00, mk(32'h00c08093, 8'h00, 1'b1, 8'h04, 1'b0));

`ifdef FETCH_PERF_EN
    cmp("perf_reset_stall", {16'h0, stall_cycles}, 32'd0);
    cmp("perf_reset_flush", {16'h0, flush_cycles}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("pstall%0d", i), 1'b1, 1'b0, 8'h00,
           mk(32'h00c08093, 8'h00, 1'b1, 8'h04, 1'b0));
    end
    step("pflush0", 1'b1, 1'b1, 8'h40, mk(NOP, 8'h04, 1'b0, 8'h40, 1'b0));
    step("pflush1", 1'b0, 1'b1, 8'h00, mk(NOP, 8'h40, 1'b0, 8'h00, 1'b0));
    cmp("perf_stall", {16'h0, stall_cycles}, 32'd5);
    cmp("perf_flush", {16'h0, flush_cycles}, 32'd2);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
